la_cmd_bridge: RTL and testbench

//  Logic-analyzer command bridge in user_project_wrapper. Management SoC firmware drives LA probes.

---
 rtl/la_cmd_bridge_pkg.sv | 35 +++
 rtl/la_cmd_bridge_if.sv | 20 ++
 rtl/la_cmd_bridge_sa_res_fifo.sv | 45 ++++
 rtl/la_cmd_bridge.sv | 154 +++++++++++++++
 tb/tb_la_cmd_bridge.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/la_cmd_bridge_pkg.sv
// Shared constants for the LA command bridge: opcodes, LA bit-field positions,
// status word layout and the PUSH handshake state type.
package la_bridge_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_SIG  = 4'd1;
  localparam logic [3:0] OP_PUSH = 4'd2;
  localparam logic [3:0] OP_POP  = 4'd3;
  localparam logic [3:0] OP_CLR  = 4'd4;

  localparam int LA_TOG_BIT = 127;
  localparam int LA_OP_MSB  = 99;
  localparam int LA_OP_LSB  = 96;
  localparam int LA_PAY_MSB = 31;

  // Bit positions inside the 32-bit status word (la_data_out[127:96])
  localparam int ST_BUSY    = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_UDF     = 2;
  localparam int ST_DROP    = 3;
  localparam int ST_BAD     = 4;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [0:0] {
    PS_IDLE = 1'b0,
    PS_HOLD = 1'b1
  } push_state_t;

  function automatic logic [31:0] pack_status(input logic [7:0] cnt, input logic bad,
                                              input logic drop, input logic udf,
                                              input logic ovf, input logic busy);
    return {16'h0000, cnt, 3'b000, bad, drop, udf, ovf, busy};
  endfunction

endpackage

// File: rtl/la_cmd_bridge_if.sv
// Operand/result handshake between the command bridge and the systolic array.
interface la_cmd_bridge_if;
  logic        sa_valid;
  logic [3:0]  sa_op;
  logic [31:0] sa_data;
  logic        sa_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;

  modport master (
    output sa_valid, sa_op, sa_data, res_ready,
    input  sa_ready, res_valid, res_data
  );

  modport slave (
    input  sa_valid, sa_op, sa_data, res_ready,
    output sa_ready, res_valid, res_data
  );
endinterface

// File: rtl/la_cmd_bridge_sa_res_fifo.sv
// Synchronous result FIFO; pointers carry one extra wrap bit so full/empty
// fall out of a simple compare. Clear overrides push and pop.
module sa_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clr,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign rdata = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end
endmodule

// File: rtl/la_cmd_bridge.sv
// LA command bridge: toggle-triggered command decode from management firmware,
// operand streaming to the systolic array, buffered results and status readback.
module la_cmd_bridge
  import la_bridge_pkg::*;
#(
  parameter int          RES_DEPTH = 4,
  parameter logic [15:0] SIG_RESET = 16'h0000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [127:0]  la_data_in,
  input  logic [127:0]  la_oenb,
  output logic [127:0]  la_data_out,
  output logic [37:0]   io_out,
  output logic [37:0]   io_oeb,
  la_cmd_bridge_if.master sa_if
);
  localparam int CW = $clog2(RES_DEPTH) + 1;

  logic        tog_reg;
  logic        cmd_pend_reg;
  logic [3:0]  cmd_op_reg;
  logic [31:0] cmd_pay_reg;
  push_state_t push_state_reg, push_state_next;
  logic [3:0]  sa_op_reg;
  logic [31:0] sa_data_reg;
  logic [15:0] sig_reg;
  logic [31:0] rd_data_reg;
  logic [31:0] status_reg;
  logic        err_ovf_reg, err_udf_reg, err_drop_reg, err_bad_reg;

  logic          fifo_full, fifo_empty, fifo_push;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_head;

  logic        cmd_fire, busy;
  logic [3:0]  cmd_op_in;
  logic [31:0] cmd_pay_in;
  logic        exec_sig, exec_push, exec_pop, exec_udf, exec_clr, exec_bad;
  logic        unused_bits;

  // Only mgmt-driven LA bits carry meaning; undriven ones read as zero.
  assign cmd_fire   = !la_oenb[LA_TOG_BIT] && (la_data_in[LA_TOG_BIT] != tog_reg);
  assign cmd_op_in  = la_data_in[LA_OP_MSB:LA_OP_LSB] & ~la_oenb[LA_OP_MSB:LA_OP_LSB];
  assign cmd_pay_in = la_data_in[LA_PAY_MSB:0] & ~la_oenb[LA_PAY_MSB:0];
  assign unused_bits = ^{la_data_in[126:100], la_data_in[95:32],
                         la_oenb[126:100], la_oenb[95:32]};

  // A PUSH counts as busy from the moment it is latched, so back-to-back toggles collide.
  assign busy = (push_state_reg == PS_HOLD) || (cmd_pend_reg && cmd_op_reg == OP_PUSH);

  always_comb begin
    exec_sig  = 1'b0;
    exec_push = 1'b0;
    exec_pop  = 1'b0;
    exec_udf  = 1'b0;
    exec_clr  = 1'b0;
    exec_bad  = 1'b0;
    if (cmd_pend_reg) begin
      case (cmd_op_reg)
        OP_NOP:  ;
        OP_SIG:  exec_sig  = 1'b1;
        OP_PUSH: exec_push = 1'b1;
        OP_POP:  begin
          exec_pop = !fifo_empty;
          exec_udf = fifo_empty;
        end
        OP_CLR:  exec_clr  = 1'b1;
        default: exec_bad  = 1'b1;
      endcase
    end
  end

  always_comb begin
    push_state_next = push_state_reg;
    case (push_state_reg)
      PS_IDLE: if (exec_push) push_state_next = PS_HOLD;
      PS_HOLD: if (sa_if.sa_ready) push_state_next = PS_IDLE;
      default: push_state_next = PS_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) push_state_reg <= PS_IDLE;
    else          push_state_reg <= push_state_next;
  end

  assign fifo_push = sa_if.res_valid && !fifo_full;

  sa_res_fifo #(.DEPTH(RES_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (wb_clk_i),
    .srst  (wb_rst_i),
    .push  (fifo_push),
    .pop   (exec_pop),
    .clr   (exec_clr),
    .wdata (sa_if.res_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge wb_clk_i) begin
    // Tracking the toggle through reset keeps reset release from firing a command.
    tog_reg <= la_data_in[LA_TOG_BIT];
    if (wb_rst_i) begin
      cmd_pend_reg <= 1'b0;
      cmd_op_reg   <= OP_NOP;
      cmd_pay_reg  <= '0;
      sa_op_reg    <= '0;
      sa_data_reg  <= '0;
      sig_reg      <= SIG_RESET;
      rd_data_reg  <= '0;
      status_reg   <= '0;
      err_ovf_reg  <= 1'b0;
      err_udf_reg  <= 1'b0;
      err_drop_reg <= 1'b0;
      err_bad_reg  <= 1'b0;
    end else begin
      cmd_pend_reg <= cmd_fire && !busy;
      if (cmd_fire && !busy) begin
        cmd_op_reg  <= cmd_op_in;
        cmd_pay_reg <= cmd_pay_in;
      end
      if (exec_push) begin
        sa_op_reg   <= cmd_op_reg;
        sa_data_reg <= cmd_pay_reg;
      end
      if (exec_sig) sig_reg     <= cmd_pay_reg[15:0];
      if (exec_pop) rd_data_reg <= fifo_head;
      if (cmd_fire && busy)                err_ovf_reg  <= 1'b1;
      if (exec_udf)                        err_udf_reg  <= 1'b1;
      if (sa_if.res_valid && fifo_full)    err_drop_reg <= 1'b1;
      if (exec_bad)                        err_bad_reg  <= 1'b1;
      if (exec_clr) begin
        err_ovf_reg  <= 1'b0;
        err_udf_reg  <= 1'b0;
        err_drop_reg <= 1'b0;
        err_bad_reg  <= 1'b0;
      end
      status_reg <= pack_status(8'(fifo_count), err_bad_reg, err_drop_reg,
                                err_udf_reg, err_ovf_reg, busy);
    end
  end

  assign sa_if.sa_valid  = (push_state_reg == PS_HOLD);
  assign sa_if.sa_op     = sa_op_reg;
  assign sa_if.sa_data   = sa_data_reg;
  assign sa_if.res_ready = !fifo_full;

  assign la_data_out = {status_reg, 64'h0, rd_data_reg};
  assign io_out      = {6'h00, sig_reg, 16'h0000};
  assign io_oeb      = {6'h3F, 16'h0000, 16'hFFFF};
endmodule

// File: tb/tb_la_cmd_bridge.sv
// Directed bench for la_cmd_bridge: drives LA commands and array handshakes,
// compares against hand-computed values, one line per comparison.
module tb_la_cmd_bridge;
  logic         clk;
  logic         rst;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;
  logic [37:0]  io_out;
  logic [37:0]  io_oeb;
  int           n_vec;
  int           n_err;
  int           xfer_cnt;

  la_cmd_bridge_if u_if ();

  la_cmd_bridge #(.RES_DEPTH(4), .SIG_RESET(16'h0000)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .la_data_in  (la_data_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_data_out),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .sa_if       (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u_if.sa_valid && u_if.sa_ready) xfer_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flip the toggle with the given command; returns just after the latching edge.
  task automatic fire(input logic [3:0] op, input logic [31:0] pay);
    la_data_in[99:96] = op;
    la_data_in[31:0]  = pay;
    la_data_in[127]   = ~la_data_in[127];
    tick();
  endtask

  function automatic logic [31:0] status();
    return la_data_out[127:96];
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    xfer_cnt = 0;
    rst = 1'b1;
    la_data_in = '0;
    la_oenb = '0;
    u_if.sa_ready = 1'b0;
    u_if.res_valid = 1'b0;
    u_if.res_data = '0;
    tick();
    tick();

    check("rst_sig", 64'(io_out[31:16]), 64'h0000);
    check("rst_la_out", 64'(la_data_out[63:0]), 64'h0);
    check("rst_status", 64'(status()), 64'h0);
    check("rst_sa_valid", 64'(u_if.sa_valid), 64'h0);
    check("rst_res_ready", 64'(u_if.res_ready), 64'h1);
    check("io_oeb", 64'(io_oeb), 64'h3F_0000_FFFF);
    rst = 1'b0;
    tick();
    check("no_fire_on_release", 64'(io_out), 64'h0);

    // Signature writes land one cycle after the latching edge
    fire(4'd1, 32'h0000_AB60);
    check("sig_before_exec", 64'(io_out[31:16]), 64'h0000);
    tick();
    check("sig_ab60", 64'(io_out[31:16]), 64'hAB60);
    fire(4'd1, 32'h0000_AB61);
    tick();
    check("sig_ab61", 64'(io_out[31:16]), 64'hAB61);
    check("io_out_other_bits", 64'(io_out & 38'h3F_0000_FFFF), 64'h0);

    // PUSH held against sa_ready low, with a colliding command
    fire(4'd2, 32'h1234_5678);
    tick();
    check("push_valid", 64'(u_if.sa_valid), 64'h1);
    check("push_data", 64'(u_if.sa_data), 64'h1234_5678);
    check("push_op", 64'(u_if.sa_op), 64'h2);
    check("push_busy", 64'(status() & 32'h1), 64'h1);
    tick();
    tick();
    check("push_hold_data", 64'(u_if.sa_data), 64'h1234_5678);
    fire(4'd1, 32'h0000_5555);
    tick();
    check("collide_ovf", 64'(status() & 32'h3), 64'h3);
    check("collide_valid", 64'(u_if.sa_valid), 64'h1);
    u_if.sa_ready = 1'b1;
    tick();
    u_if.sa_ready = 1'b0;
    check("push_done_valid", 64'(u_if.sa_valid), 64'h0);
    tick();
    tick();
    check("xfer_count", 64'(xfer_cnt), 64'd1);
    check("dropped_sig", 64'(io_out[31:16]), 64'hAB61);

    // Fill the result FIFO, overflow it, then drain in order
    u_if.res_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_if.res_data = 32'hA0 + 32'(i);
      tick();
    end
    check("full_res_ready", 64'(u_if.res_ready), 64'h0);
    u_if.res_data = 32'hA4;
    tick();
    u_if.res_valid = 1'b0;
    tick();
    check("drop_status", 64'(status() & 32'h0000_FF08), 64'h0000_0408);
    for (int i = 0; i < 4; i++) begin
      fire(4'd3, 32'h0);
      tick();
      check($sformatf("pop_%0d", i), 64'(la_data_out[31:0]), 64'hA0 + 64'(i));
    end

    // POP coincident with a result write at count 2
    u_if.res_valid = 1'b1;
    u_if.res_data = 32'hB0;
    tick();
    u_if.res_data = 32'hB1;
    tick();
    u_if.res_valid = 1'b0;
    fire(4'd3, 32'h0);
    u_if.res_valid = 1'b1;
    u_if.res_data = 32'hB2;
    tick();
    u_if.res_valid = 1'b0;
    check("popw_head", 64'(la_data_out[31:0]), 64'hB0);
    tick();
    check("popw_count", 64'((status() >> 8) & 32'hFF), 64'd2);
    fire(4'd3, 32'h0);
    tick();
    check("popw_b1", 64'(la_data_out[31:0]), 64'hB1);
    fire(4'd3, 32'h0);
    tick();
    check("popw_b2", 64'(la_data_out[31:0]), 64'hB2);

    // Underflow, then CLR racing a result write
    fire(4'd3, 32'h0);
    tick();
    tick();
    check("udf_flag", 64'(status() & 32'h4), 64'h4);
    check("udf_data_kept", 64'(la_data_out[31:0]), 64'hB2);
    u_if.res_valid = 1'b1;
    u_if.res_data = 32'hC0;
    tick();
    u_if.res_valid = 1'b0;
    fire(4'd4, 32'h0);
    u_if.res_valid = 1'b1;
    u_if.res_data = 32'hC1;
    tick();
    u_if.res_valid = 1'b0;
    tick();
    check("clr_status", 64'(status()), 64'h0);
    check("clr_res_ready", 64'(u_if.res_ready), 64'h1);

    // Toggle while the toggle bit is not mgmt-driven
    la_oenb[127] = 1'b1;
    la_data_in[99:96] = 4'd1;
    la_data_in[31:0] = 32'h0000_1111;
    la_data_in[127] = ~la_data_in[127];
    tick();
    tick();
    la_oenb[127] = 1'b0;
    tick();
    tick();
    check("oenb_no_cmd", 64'(io_out[31:16]), 64'hAB61);

    fire(4'hA, 32'h0);
    tick();
    tick();
    check("bad_opcode", 64'(status() & 32'h10), 64'h10);

    // Reset in the middle of a held PUSH
    fire(4'd2, 32'hDEAD_BEEF);
    tick();
    check("rst_push_valid", 64'(u_if.sa_valid), 64'h1);
    rst = 1'b1;
    tick();
    check("rst_mid_valid", 64'(u_if.sa_valid), 64'h0);
    check("rst_mid_sig", 64'(io_out[31:16]), 64'h0000);
    check("rst_mid_status", 64'(status()), 64'h0);
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_valid", 64'(u_if.sa_valid), 64'h0);
    check("post_rst_xfers", 64'(xfer_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
